// File: rtl/garland_seq.sv
// Parametrised LED garland sequencer: prescaled step timing, four runtime-selectable
// patterns, registered LED drive with step and cycle-done strobes.
module garland_seq #(
  parameter int N_LED       = 8,
  parameter int DIV_W       = 20,
  parameter int STEP_TICKS  = 16,
  parameter int FLASH_COUNT = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [1:0]       MODE,
  output logic [N_LED-1:0] LED,
  output logic             STEP_STB,
  output logic             CYCLE_DONE
);

  localparam int H      = N_LED / 2;
  localparam int LEN0   = H + 2 * FLASH_COUNT;
  localparam int LEN1   = N_LED;
  localparam int LEN2   = 2 * N_LED - 2;
  localparam int LEN3   = 2;
  localparam int MAXLEN = (LEN2 > LEN0) ? LEN2 : LEN0;
  localparam int IDX_W  = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam bit H_ODD  = (H % 2) == 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       stc_q, stc_d;
  logic [IDX_W-1:0] idx_q, idx_d, last_idx;
  logic [1:0]       mode_q, mode_d;
  logic [N_LED-1:0] led_q, led_d, pat;
  logic             stb_q, stb_d, done_q, done_d;
  logic             tick, step;
  logic [31:0]      idx_w;

  assign idx_w = 32'(idx_q);
  assign tick  = EN && (div_q == '1);
  assign step  = tick && (stc_q == 8'(STEP_TICKS - 1));

  // Per-bit pattern decode from the current mode and element index.
  genvar gi;
  generate
    for (gi = 0; gi < N_LED; gi++) begin : g_pat
      assign pat[gi] =
        (mode_q == 2'd0) ? ((idx_w < 32'(H))
                              ? ((32'(gi) + idx_w == 32'(H - 1)) || (32'(gi) == idx_w + 32'(H)))
                              : (idx_q[0] != H_ODD)) :
        (mode_q == 2'd1) ? (32'(gi) == idx_w) :
        (mode_q == 2'd2) ? ((idx_w < 32'(N_LED))
                              ? (32'(gi) == idx_w)
                              : (32'(gi) + idx_w == 32'(2 * N_LED - 2))) :
                           (idx_q == '0);
    end
  endgenerate

  always_comb begin
    last_idx = IDX_W'(LEN0 - 1);
    case (mode_q)
      2'd0:    last_idx = IDX_W'(LEN0 - 1);
      2'd1:    last_idx = IDX_W'(LEN1 - 1);
      2'd2:    last_idx = IDX_W'(LEN2 - 1);
      default: last_idx = IDX_W'(LEN3 - 1);
    endcase
  end

  always_comb begin
    div_d  = div_q;
    stc_d  = stc_q;
    idx_d  = idx_q;
    led_d  = led_q;
    mode_d = mode_q;
    stb_d  = 1'b0;
    done_d = 1'b0;
    if (MODE != mode_q) begin
      // A mode change restarts the pattern and swallows any coincident step.
      mode_d = MODE;
      idx_d  = '0;
      led_d  = '0;
      div_d  = '0;
      stc_d  = '0;
    end else if (EN) begin
      div_d = div_q + DIV_W'(1);
      if (tick) stc_d = step ? 8'd0 : stc_q + 8'd1;
      if (step) begin
        led_d  = pat;
        idx_d  = (idx_q == last_idx) ? '0 : idx_q + IDX_W'(1);
        stb_d  = 1'b1;
        done_d = (idx_q == last_idx);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q  <= '0;
      stc_q  <= '0;
      idx_q  <= '0;
      led_q  <= '0;
      mode_q <= MODE;
      stb_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      stc_q  <= stc_d;
      idx_q  <= idx_d;
      led_q  <= led_d;
      mode_q <= mode_d;
      stb_q  <= stb_d;
      done_q <= done_d;
    end
  end

  assign LED        = led_q;
  assign STEP_STB   = stb_q;
  assign CYCLE_DONE = done_q;

endmodule

// File: tb/tb_garland_seq.sv
// Bench for garland_seq: literal step-sequence table, hand-built timing corner cases,
// and a randomized run against a step-count reference model.
module tb_garland_seq;
  localparam int N   = 8;
  localparam int DW  = 2;
  localparam int ST  = 2;
  localparam int FC  = 2;
  localparam int H   = N / 2;
  localparam int PER = ST * (1 << DW);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b1;
  logic [1:0]   mode = 2'd0;
  logic [N-1:0] led;
  logic         stb, done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  garland_seq #(.N_LED(N), .DIV_W(DW), .STEP_TICKS(ST), .FLASH_COUNT(FC)) dut (
    .CLK(clk), .RST(rst), .EN(en), .MODE(mode),
    .LED(led), .STEP_STB(stb), .CYCLE_DONE(done)
  );

  typedef struct {
    logic [1:0] mode;
    logic [7:0] led;
    logic       done;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [1:0] m);
    rst  = 1'b1;
    mode = m;
    en   = 1'b1;
    tick();
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_strobes", {30'd0, stb, done}, 32'h0);
    rst = 1'b0;
  endtask

  // Counts clocks until the next STEP_STB; a timeout yields an impossible gap.
  task automatic wait_step(output int gap);
    gap = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      gap++;
      if (stb) return;
    end
    gap = 999;
  endtask

  task automatic add_vec(input logic [1:0] m, input logic [7:0] l, input logic d);
    vec_t v;
    v.mode = m;
    v.led  = l;
    v.done = d;
    vecs.push_back(v);
  endtask

  function automatic int ref_len(input int m);
    case (m)
      0:       return H + 2 * FC;
      1:       return N;
      2:       return 2 * N - 2;
      default: return 2;
    endcase
  endfunction

  function automatic logic [7:0] ref_pat(input int m, input int e);
    case (m)
      0: begin
        if (e < H) return (8'(1) << (H - 1 - e)) | (8'(1) << (H + e));
        return (((e - H) % 2) == 1) ? 8'hFF : 8'h00;
      end
      1: return 8'(1) << e;
      2: return (e < N) ? (8'(1) << e) : (8'(1) << (2 * N - 2 - e));
      default: return (e == 0) ? 8'hFF : 8'h00;
    endcase
  endfunction

  int         gap, prev_mode;
  logic [7:0] held;
  bit         saw_stb, saw_change;
  // reference model state
  int         m_mode, m_cnt, m_steps, m_e;
  logic [7:0] m_led;
  logic       m_stb, m_done;

  initial begin
    add_vec(0, 8'h18, 0); add_vec(0, 8'h24, 0); add_vec(0, 8'h42, 0); add_vec(0, 8'h81, 0);
    add_vec(0, 8'h00, 0); add_vec(0, 8'hFF, 0); add_vec(0, 8'h00, 0); add_vec(0, 8'hFF, 1);
    add_vec(0, 8'h18, 0);
    for (int i = 0; i < 8; i++) add_vec(1, 8'(1) << i, (i == 7));
    add_vec(1, 8'h01, 0);
    for (int i = 0; i < 8; i++) add_vec(2, 8'(1) << i, 0);
    for (int i = 6; i >= 1; i--) add_vec(2, 8'(1) << i, (i == 1));
    add_vec(2, 8'h01, 0);

    // Table: each mode run from reset, one line per step.
    prev_mode = -1;
    for (int i = 0; i < vecs.size(); i++) begin
      if (int'(vecs[i].mode) != prev_mode) begin
        do_reset(vecs[i].mode);
        prev_mode = int'(vecs[i].mode);
      end
      wait_step(gap);
      chk("vec_gap", 32'(gap), 32'(PER));
      chk("vec_led", 32'(led), 32'(vecs[i].led));
      chk("vec_done", 32'(done), 32'(vecs[i].done));
      $display("vec %0d mode %0d: led=0x%02h done=%0b gap=%0d", i, vecs[i].mode, led, done, gap);
    end

    // Blink with EN dropped for 20 cycles, 3 cycles into a step period.
    do_reset(2'd3);
    wait_step(gap);
    chk("blink_first", 32'(led), 32'hFF);
    for (int c = 0; c < 3; c++) tick();
    en = 1'b0;
    held = led;
    saw_stb = 1'b0;
    saw_change = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (stb || done) saw_stb = 1'b1;
      if (led != held) saw_change = 1'b1;
    end
    chk("pause_strobes", 32'(saw_stb), 32'h0);
    chk("pause_led_hold", 32'(saw_change), 32'h0);
    en = 1'b1;
    wait_step(gap);
    chk("resume_gap", 32'(gap), 32'(PER - 3));
    chk("resume_led", 32'(led), 32'h00);
    chk("resume_done", 32'(done), 32'h1);
    $display("blink pause: resume gap=%0d led=0x%02h done=%0b", gap, led, done);

    // Mode 1 -> 2 on the edge a step would fire.
    do_reset(2'd1);
    wait_step(gap);
    chk("chase_first", 32'(led), 32'h01);
    for (int c = 0; c < PER - 1; c++) tick();
    mode = 2'd2;
    tick();
    chk("modechg_led", 32'(led), 32'h0);
    chk("modechg_stb", 32'(stb), 32'h0);
    wait_step(gap);
    chk("modechg_gap", 32'(gap), 32'(PER));
    chk("modechg_new_led", 32'(led), 32'h01);
    $display("mode change: gap=%0d led=0x%02h", gap, led);

    // Reset mid-pattern while showing 0x42.
    do_reset(2'd0);
    for (int s = 0; s < 3; s++) wait_step(gap);
    chk("midrst_pre", 32'(led), 32'h42);
    rst = 1'b1;
    tick();
    chk("midrst_led", 32'(led), 32'h0);
    chk("midrst_strobes", {30'd0, stb, done}, 32'h0);
    rst = 1'b0;
    wait_step(gap);
    chk("midrst_gap", 32'(gap), 32'(PER));
    chk("midrst_led_after", 32'(led), 32'h18);
    $display("mid reset: gap=%0d led=0x%02h", gap, led);

    // Randomized run against the step-count model.
    do_reset(2'($urandom_range(0, 3)));
    m_mode = int'(mode); m_cnt = 0; m_steps = 0; m_led = 0; m_stb = 0; m_done = 0;
    for (int c = 0; c < 3000; c++) begin
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      m_stb = 0;
      m_done = 0;
      if (rst || int'(mode) != m_mode) begin
        m_mode = int'(mode); m_cnt = 0; m_steps = 0; m_led = 0;
      end else if (en) begin
        m_cnt++;
        if (m_cnt % PER == 0) begin
          m_e    = m_steps % ref_len(m_mode);
          m_led  = ref_pat(m_mode, m_e);
          m_stb  = 1;
          m_done = (m_e == ref_len(m_mode) - 1);
          m_steps++;
        end
      end
      tick();
      chk("rnd_led", 32'(led), 32'(m_led));
      chk("rnd_strobes", {30'd0, stb, done}, {30'd0, m_stb, m_done});
    end
    rst = 1'b0;
    $display("random run: %0d model steps in final segment", m_steps);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/garland_seq.md
Name: garland_seq

Overview:
- Parametrised successor to the fixed 8-LED centre-out garland.
- Drives N_LED LEDs from one system clock using an internal clock-enable prescaler. It does not use derived clocks.
- Four runtime-selectable patterns: centre-out pair sweep with all-LED flash tail, chase, ping-pong and blink-all.
- Has a run enable, plus step and cycle-done strobes for chaining and debug. Sits directly under the board top, driving the LED pins.

Parameters:
- N_LED, 8, number of LEDs; even, 2..32.
- DIV_W, 20, prescaler width; one tick every 2^DIV_W CLK cycles.
- STEP_TICKS, 16, ticks per pattern step; 1..255.
- FLASH_COUNT, 2, off/on flash pairs appended to the centre-out sweep; 0..15.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- EN  in  1  run enable; low freezes everything.
- MODE  in  2  pattern select: 0 centre-out, 1 chase, 2 ping-pong, 3 blink.
- LED  out  N_LED  registered LED drive, 1 = lit.
- STEP_STB  out  1  one-cycle pulse, coincident with each LED update.
- CYCLE_DONE  out  1  one-cycle pulse, coincident with the update showing the last element of the pattern.

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RST; all state is updated only on posedge CLK.
- RST has priority over everything. Reset values:
  - LED=0, STEP_STB=0, CYCLE_DONE=0.
  - Prescaler=0, step counter=0, pattern index idx=0.
  - mode_q=MODE as sampled in the reset cycle.
- Prescaler (only while EN=1):
  - DIV_W-bit up-counter.
  - tick is an internal 1-cycle flag, true when the counter equals all-ones; the counter then wraps to 0.
- Step counter (only while EN=1):
  - Advances on tick.
  - step is true when tick=1 and step counter = STEP_TICKS-1; the counter then returns to 0.
  - Step period = STEP_TICKS*2^DIV_W cycles.
- On the clock edge where step is true, in one update:
  - LED <= pattern(mode_q, idx).
  - idx advances, wrapping after the last element.
  - STEP_STB <= 1.
  - CYCLE_DONE <= 1 if idx was the last element.
- On all other edges STEP_STB=0 and CYCLE_DONE=0. The first LED update after reset shows element 0. Until then LED stays 0.
- Patterns, with H=N_LED/2:
  - Mode 0, length H+2*FLASH_COUNT:
    - For idx<H: only bits H-1-idx and H+idx are lit.
    - For idx>=H: with k=idx-H, even k gives all off and odd k gives all on.
  - Mode 1, length N_LED: one-hot, bit idx.
  - Mode 2, length 2*N_LED-2:
    - For idx<N_LED: one-hot, bit idx.
    - Otherwise: one-hot, bit 2*N_LED-2-idx.
    - End LEDs are not repeated.
  - Mode 3, length 2: idx 0 gives all on; idx 1 gives all off.
- Mode change: on any edge where MODE != mode_q (and RST=0):
  - mode_q<=MODE, idx<=0, LED<=0.
  - Prescaler and step counter are cleared.
  - STEP_STB=0 and CYCLE_DONE=0.
  - Mode change beats a coincident step; that step is dropped. This applies regardless of EN.
- EN=0: prescaler, step counter, idx and LED all hold; strobes are 0. Resuming continues from the held count with no extra or lost ticks.
- idx width is sized for the longest pattern, which is 2*N_LED-2 or H+2*FLASH_COUNT, whichever is greater. Wrap is by compare, not by natural overflow.

Test Plan (N_LED=8, DIV_W=2, STEP_TICKS=2, FLASH_COUNT=2, so one step every 8 CLK):
- Reset, MODE=0, EN=1:
  - First step at cycle 8 after RST is released.
  - LED sequence 0x18,0x24,0x42,0x81,0x00,0xFF,0x00,0xFF, then repeats.
  - CYCLE_DONE is high only with the 0xFF at step 8.
  - STEP_STB is exactly 1 cycle wide, every 8 cycles.
- MODE=1 from reset: LED sequence 0x01,0x02,…,0x80,0x01; CYCLE_DONE fires with 0x80.
- MODE=2: sequence 0x01..0x80, then 0x40..0x02, then 0x01. Period is 14 steps; CYCLE_DONE fires with 0x02.
- MODE=3 with EN dropped for 20 cycles mid-step:
  - LED toggles 0xFF/0x00.
  - With EN low, no strobes and LED holds.
  - After EN returns, the next step arrives exactly (8 minus elapsed pre-pause cycles) clocks later.
- Change MODE 1→2 on the same cycle a step would fire: LED=0 on the next cycle, no STEP_STB, and 8 cycles later LED=0x01.
- Assert RST mid-pattern (mode 0, LED=0x42): next cycle LED=0 and strobes 0. First post-reset step, 8 cycles after RST is released, shows 0x18.
